// File: rtl/eth_pkg.sv
// Shared RMII framing definitions for eth_packer / eth_unpacker: field lengths,
// preamble/SFD dibits, receiver state encoding and the CRC-32 dibit step.
package eth_pkg;

    localparam int ETH_PRE_MIN_DIBITS = 8;
    localparam int ETH_ADDR_DIBITS    = 24;
    localparam int ETH_LEN_DIBITS     = 8;
    localparam int ETH_DATA_DIBITS    = 20;
    localparam int ETH_CRC_DIBITS     = 16;

    localparam logic [1:0]  DIBIT_PREAMBLE  = 2'b01;
    localparam logic [1:0]  DIBIT_SFD       = 2'b11;
    localparam logic [1:0]  DIBIT_BCAST     = 2'b11;
    localparam logic [12:0] CNT_MAX         = 13'h1FFF;
    localparam logic [31:0] CRC32_POLY_REFL = 32'hEDB8_8320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_WAIT_QUIET = 3'd0,
        ST_IDLE       = 3'd1,
        ST_PREAMBLE   = 3'd2,
        ST_DEST_ADDR  = 3'd3,
        ST_SRC_ADDR   = 3'd4,
        ST_LENGTH     = 3'd5,
        ST_DATA       = 3'd6,
        ST_FCS        = 3'd7
    } eth_state_t;

    // Reflected CRC-32 advanced by one dibit; rxd[0] is the earlier bit on the wire.
    function automatic logic [31:0] crc32_dibit(input logic [31:0] crc, input logic [1:0] d);
        logic [31:0] c;
        c = crc;
        for (int i = 0; i < 2; i++) begin
            if (c[0] ^ d[i]) begin
                c = (c >> 1) ^ CRC32_POLY_REFL;
            end else begin
                c = c >> 1;
            end
        end
        return c;
    endfunction

    // FCS dibit k lands at {b+1,b}: bytes reversed, bits LSB-first within a byte.
    function automatic logic [4:0] fcs_bit_pos(input logic [3:0] k);
        return 5'd24 - {k[3:2], 3'b000} + {2'b00, k[1:0], 1'b0};
    endfunction

endpackage

// File: rtl/crc32.sv
// Dibit-serial Ethernet CRC-32; axiod presents the FCS byte-swapped so it can be
// compared directly against a received FCS assembled in wire order.
module crc32
    import eth_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        axiiv,
    input  logic [1:0]  axiid,
    output logic        axiov,
    output logic [31:0] axiod
);
    logic [31:0] crc_q, crc_d;
    logic        axiov_q;

    // Next CRC state: advance only on valid dibits.
    always_comb begin
        if (axiiv) begin
            crc_d = crc32_dibit(crc_q, axiid);
        end else begin
            crc_d = crc_q;
        end
    end

    // CRC register and one-cycle-delayed valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            crc_q   <= CRC32_INIT;
            axiov_q <= 1'b0;
        end else begin
            crc_q   <= crc_d;
            axiov_q <= axiiv;
        end
    end

    assign axiov = axiov_q;
    assign axiod = {~crc_q[7:0], ~crc_q[15:8], ~crc_q[23:16], ~crc_q[31:24]};

endmodule

// File: rtl/eth_unpacker.sv
// Receive-side RMII framer: locks on preamble/SFD, skips the header, streams the
// payload dibits and checks the trailing FCS against a local CRC-32.
module eth_unpacker
    import eth_pkg::*;
#(
    parameter int PRE_MIN_DIBITS = ETH_PRE_MIN_DIBITS,
    parameter int ADDR_DIBITS    = ETH_ADDR_DIBITS,
    parameter int LEN_DIBITS     = ETH_LEN_DIBITS,
    parameter int DATA_DIBITS    = ETH_DATA_DIBITS,
    parameter int CRC_DIBITS     = ETH_CRC_DIBITS
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       crsdv,
    input  logic [1:0] rxd,
    output logic       axiov,
    output logic [1:0] axiod,
    output logic       dest_ok,
    output logic       frame_done,
    output logic       crc_ok,
    output logic       frame_err
);
    eth_state_t  state_q, state_d;
    logic [12:0] cnt_q, cnt_d;
    logic        axiov_q, axiov_d;
    logic [1:0]  axiod_q, axiod_d;
    logic        dest_ok_q, dest_ok_d;
    logic        frame_done_q, frame_done_d;
    logic        crc_ok_q, crc_ok_d;
    logic        frame_err_q, frame_err_d;
    logic [31:0] rx_fcs_q, rx_fcs_d;
    logic [31:0] crc_cap_q, crc_cap_d;

    logic        in_body_s, crc_in_v_s, crc_rst_s, crc_out_v_s;
    logic [31:0] crc_out_s, crc_ref_s;
    logic [4:0]  fcs_pos_s;
    logic [12:0] cnt_inc_s;

    assign in_body_s  = (state_q inside {ST_DEST_ADDR, ST_SRC_ADDR, ST_LENGTH, ST_DATA, ST_FCS});
    assign crc_in_v_s = crsdv && (state_q inside {ST_DEST_ADDR, ST_SRC_ADDR, ST_LENGTH, ST_DATA});
    assign crc_rst_s  = rst || !in_body_s;
    assign fcs_pos_s  = fcs_bit_pos(cnt_q[3:0]);
    assign cnt_inc_s  = cnt_q + 13'd1;
    // The CRC settles one cycle after the last data dibit, i.e. on the first FCS cycle.
    assign crc_ref_s  = ((cnt_q == 13'd0) && crc_out_v_s) ? crc_out_s : crc_cap_q;

    crc32 u_crc32 (
        .clk   (clk),
        .rst   (crc_rst_s),
        .axiiv (crc_in_v_s),
        .axiid (rxd),
        .axiov (crc_out_v_s),
        .axiod (crc_out_s)
    );

    // Frame state machine and next values of all registered outputs.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        axiov_d      = 1'b0;
        axiod_d      = 2'b00;
        dest_ok_d    = dest_ok_q;
        frame_done_d = 1'b0;
        crc_ok_d     = 1'b0;
        frame_err_d  = 1'b0;
        rx_fcs_d     = rx_fcs_q;
        crc_cap_d    = crc_cap_q;
        if (in_body_s && !crsdv) begin
            frame_err_d = 1'b1;
            state_d     = ST_IDLE;
            cnt_d       = 13'd0;
        end else begin
            case (state_q)
                ST_WAIT_QUIET: begin
                    if (!crsdv) begin
                        state_d = ST_IDLE;
                        cnt_d   = 13'd0;
                    end else begin
                        state_d = ST_WAIT_QUIET;
                    end
                end
                ST_IDLE: begin
                    if (crsdv && (rxd == DIBIT_PREAMBLE)) begin
                        state_d = ST_PREAMBLE;
                        cnt_d   = 13'd1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_PREAMBLE: begin
                    if (crsdv && (rxd == DIBIT_PREAMBLE)) begin
                        cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_inc_s;
                    end else if (crsdv && (rxd == DIBIT_SFD) && (cnt_q >= 13'(PRE_MIN_DIBITS))) begin
                        state_d   = ST_DEST_ADDR;
                        cnt_d     = 13'd0;
                        dest_ok_d = 1'b1;
                    end else begin
                        state_d = ST_WAIT_QUIET;
                        cnt_d   = 13'd0;
                    end
                end
                ST_DEST_ADDR: begin
                    if (rxd != DIBIT_BCAST) begin
                        dest_ok_d = 1'b0;
                    end else begin
                        dest_ok_d = dest_ok_q;
                    end
                    if (cnt_q == 13'(ADDR_DIBITS - 1)) begin
                        state_d = ST_SRC_ADDR;
                        cnt_d   = 13'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_SRC_ADDR: begin
                    if (cnt_q == 13'(ADDR_DIBITS - 1)) begin
                        state_d = ST_LENGTH;
                        cnt_d   = 13'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_LENGTH: begin
                    if (cnt_q == 13'(LEN_DIBITS - 1)) begin
                        state_d = ST_DATA;
                        cnt_d   = 13'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_DATA: begin
                    axiov_d = 1'b1;
                    axiod_d = rxd;
                    if (cnt_q == 13'(DATA_DIBITS - 1)) begin
                        state_d = ST_FCS;
                        cnt_d   = 13'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                ST_FCS: begin
                    rx_fcs_d[fcs_pos_s +: 2] = rxd;
                    if (cnt_q == 13'd0) begin
                        crc_cap_d = crc_ref_s;
                    end else begin
                        crc_cap_d = crc_cap_q;
                    end
                    if (cnt_q == 13'(CRC_DIBITS - 1)) begin
                        frame_done_d = 1'b1;
                        crc_ok_d     = (rx_fcs_d == crc_ref_s);
                        state_d      = ST_WAIT_QUIET;
                        cnt_d        = 13'd0;
                    end else begin
                        cnt_d = cnt_inc_s;
                    end
                end
                default: begin
                    state_d = ST_WAIT_QUIET;
                    cnt_d   = 13'd0;
                end
            endcase
        end
    end

    // State, counter, FCS capture and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_WAIT_QUIET;
            cnt_q        <= 13'd0;
            axiov_q      <= 1'b0;
            axiod_q      <= 2'b00;
            dest_ok_q    <= 1'b0;
            frame_done_q <= 1'b0;
            crc_ok_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            rx_fcs_q     <= 32'd0;
            crc_cap_q    <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            axiov_q      <= axiov_d;
            axiod_q      <= axiod_d;
            dest_ok_q    <= dest_ok_d;
            frame_done_q <= frame_done_d;
            crc_ok_q     <= crc_ok_d;
            frame_err_q  <= frame_err_d;
            rx_fcs_q     <= rx_fcs_d;
            crc_cap_q    <= crc_cap_d;
        end
    end

    assign axiov      = axiov_q;
    assign axiod      = axiod_q;
    assign dest_ok    = dest_ok_q;
    assign frame_done = frame_done_q;
    assign crc_ok     = crc_ok_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_eth_unpacker.sv
// Bench for eth_unpacker: frames are built byte-wise with a reference Ethernet CRC,
// sent as RMII dibits, and the captured outputs are compared with expectations.
module tb_eth_unpacker;
    localparam int ADDR = 24;
    localparam int LEN  = 8;
    localparam int DATA = 20;
    localparam int CRCD = 16;
    localparam int BODY = 2 * ADDR + LEN + DATA + CRCD;
    localparam int IFG  = 48;

    typedef struct packed {
        int pre_len;
        bit bcast;
        bit rnd;
        int corrupt;
        int n_body;
        int rst_at;
        int e_ov;
        int e_done;
        int e_err;
        bit e_crc;
        bit e_dest;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, crsdv;
    logic [1:0] rxd;
    logic       axiov, dest_ok, frame_done, crc_ok, frame_err;
    logic [1:0] axiod;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int sfd_cyc = 0;

    logic [1:0] got_q[$];
    int         got_cyc[$];
    int         n_done = 0, n_err = 0, n_viol = 0, done_cyc = 0;
    logic       got_crc_ok = 1'b0, got_dest_ok = 1'b0;

    logic [7:0] body_bytes[$];
    logic [1:0] tx_q[$];
    logic [1:0] exp_pay[$];
    vec_t       tbl[$];

    eth_unpacker dut (
        .clk        (clk),
        .rst        (rst),
        .crsdv      (crsdv),
        .rxd        (rxd),
        .axiov      (axiov),
        .axiod      (axiod),
        .dest_ok    (dest_ok),
        .frame_done (frame_done),
        .crc_ok     (crc_ok),
        .frame_err  (frame_err)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (axiov) begin
            got_q.push_back(axiod);
            got_cyc.push_back(cyc);
        end
        if (frame_done) begin
            n_done      <= n_done + 1;
            done_cyc    <= cyc;
            got_crc_ok  <= crc_ok;
            got_dest_ok <= dest_ok;
        end
        if (frame_err) n_err <= n_err + 1;
        if ((crc_ok && !frame_done) || (frame_done && frame_err)) n_viol <= n_viol + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Standard byte-wise reflected CRC-32 over the header and payload bytes.
    function automatic logic [31:0] ref_fcs();
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (body_bytes[i]) begin
            c = c ^ {24'h0, body_bytes[i]};
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
        end
        return ~c;
    endfunction

    function automatic vec_t model(input vec_t v);
        vec_t r;
        bit   ok;
        r  = v;
        ok = (v.pre_len >= 8);
        r.e_ov   = !ok ? 0 : (v.n_body <= 56) ? 0 : (v.n_body >= 76) ? 20 : v.n_body - 56;
        r.e_done = (ok && v.n_body >= BODY) ? 1 : 0;
        r.e_err  = (ok && v.n_body < BODY) ? 1 : 0;
        r.e_crc  = (v.corrupt < 0);
        r.e_dest = v.bcast;
        return r;
    endfunction

    task automatic build_frame(input int pre_len, input bit bcast, input bit rnd, input int corrupt);
        logic [31:0] f;
        logic [7:0]  b;
        logic [1:0]  d;
        body_bytes.delete();
        tx_q.delete();
        exp_pay.delete();
        for (int i = 0; i < 6; i++) begin
            b = bcast ? 8'hFF : 8'($urandom);
            if (!bcast && i == 0) b[1:0] = 2'b10;
            body_bytes.push_back(b);
        end
        for (int i = 0; i < 6; i++) body_bytes.push_back(8'($urandom));
        body_bytes.push_back(8'h00);
        body_bytes.push_back(8'h05);
        for (int i = 0; i < DATA; i++) exp_pay.push_back(rnd ? 2'($urandom) : 2'(i % 4));
        for (int i = 0; i < DATA / 4; i++)
            body_bytes.push_back({exp_pay[4*i+3], exp_pay[4*i+2], exp_pay[4*i+1], exp_pay[4*i]});
        f = ref_fcs();
        for (int i = 0; i < pre_len; i++) tx_q.push_back(2'b01);
        tx_q.push_back(2'b11);
        foreach (body_bytes[i]) begin
            b = body_bytes[i];
            for (int k = 0; k < 4; k++) tx_q.push_back(b[2*k +: 2]);
        end
        for (int k = 0; k < CRCD; k++) begin
            d = f[2*k +: 2];
            if (k == corrupt) d[0] = ~d[0];
            tx_q.push_back(d);
        end
    endtask

    // Drives preamble+SFD plus n_body body dibits; beyond the frame it keeps carrier
    // up with a fake preamble/SFD that must be ignored. Optional reset pulse at body index rst_at.
    task automatic send_frame(input int n_body, input int rst_at);
        int n_pre;
        n_pre = tx_q.size() - BODY;
        for (int i = 0; i < n_pre + n_body; i++) begin
            @(negedge clk);
            if (rst_at >= 0 && i == n_pre + rst_at + 1)
                check("rst_outputs_zero", {axiov, axiod, dest_ok, frame_done, crc_ok, frame_err}, 64'd0);
            rst   = (rst_at >= 0) && (i == n_pre + rst_at);
            crsdv = 1'b1;
            if (i == n_pre - 1) sfd_cyc = cyc;
            if (i < tx_q.size()) rxd = tx_q[i];
            else rxd = (i - tx_q.size() == 12) ? 2'b11 : 2'b01;
        end
        @(negedge clk);
        rst   = 1'b0;
        crsdv = 1'b0;
        rxd   = 2'b00;
        repeat (IFG - 1) @(negedge clk);
    endtask

    task automatic run_case(input int idx, input vec_t v);
        int base_ov, base_done, base_err, bad, n_ov;
        base_ov   = got_q.size();
        base_done = n_done;
        base_err  = n_err;
        bad       = 0;
        build_frame(v.pre_len, v.bcast, v.rnd, v.corrupt);
        send_frame(v.n_body, v.rst_at);
        n_ov = got_q.size() - base_ov;
        check($sformatf("v%0d.axiov_count", idx), n_ov, v.e_ov);
        if (v.e_ov > 0 && n_ov >= v.e_ov) begin
            for (int i = 0; i < v.e_ov; i++) if (got_q[base_ov + i] !== exp_pay[i]) bad++;
            check($sformatf("v%0d.payload_errs", idx), bad, 0);
            check($sformatf("v%0d.payload_latency", idx), got_cyc[base_ov] - sfd_cyc, 58);
            check($sformatf("v%0d.payload_span", idx), got_cyc[base_ov + v.e_ov - 1] - got_cyc[base_ov], v.e_ov - 1);
        end
        check($sformatf("v%0d.frame_done_count", idx), n_done - base_done, v.e_done);
        check($sformatf("v%0d.frame_err_count", idx), n_err - base_err, v.e_err);
        if (v.e_done > 0 && n_done > base_done) begin
            check($sformatf("v%0d.crc_ok", idx), got_crc_ok, v.e_crc);
            check($sformatf("v%0d.dest_ok", idx), got_dest_ok, v.e_dest);
            check($sformatf("v%0d.done_latency", idx), done_cyc - sfd_cyc, 93);
        end
    endtask

    initial begin
        vec_t v;
        int   sel;
        // pre, bcast, rnd, corrupt, n_body, rst_at | ov, done, err, crc, dest
        tbl.push_back('{31, 1'b1, 1'b0, -1, BODY,      -1, 20, 1, 0, 1'b1, 1'b1});
        tbl.push_back('{31, 1'b1, 1'b0, -1, BODY,      -1, 20, 1, 0, 1'b1, 1'b1});
        tbl.push_back('{31, 1'b1, 1'b0, -1, BODY,      -1, 20, 1, 0, 1'b1, 1'b1});
        tbl.push_back('{31, 1'b1, 1'b0,  5, BODY,      -1, 20, 1, 0, 1'b0, 1'b1});
        tbl.push_back('{ 4, 1'b1, 1'b0, -1, BODY,      -1,  0, 0, 0, 1'b0, 1'b0});
        tbl.push_back('{ 7, 1'b1, 1'b1, -1, BODY,      -1,  0, 0, 0, 1'b0, 1'b0});
        tbl.push_back('{ 8, 1'b1, 1'b1, -1, BODY,      -1, 20, 1, 0, 1'b1, 1'b1});
        tbl.push_back('{31, 1'b1, 1'b0, -1, 66,        -1, 10, 0, 1, 1'b0, 1'b0});
        tbl.push_back('{31, 1'b1, 1'b1, -1, BODY,      -1, 20, 1, 0, 1'b1, 1'b1});
        tbl.push_back('{31, 1'b1, 1'b0, -1, BODY,      30,  0, 0, 0, 1'b0, 1'b0});
        tbl.push_back('{31, 1'b1, 1'b1, -1, BODY,      -1, 20, 1, 0, 1'b1, 1'b1});
        tbl.push_back('{31, 1'b0, 1'b1, -1, BODY,      -1, 20, 1, 0, 1'b1, 1'b0});
        tbl.push_back('{31, 1'b1, 1'b1, -1, BODY - 1,  -1, 20, 0, 1, 1'b0, 1'b0});
        tbl.push_back('{31, 1'b1, 1'b1, -1, 3,         -1,  0, 0, 1, 1'b0, 1'b0});
        tbl.push_back('{31, 1'b1, 1'b1, -1, BODY + 20, -1, 20, 1, 0, 1'b1, 1'b1});

        // Reset with carrier already up: the frame in flight must be ignored.
        rst   = 1'b1;
        crsdv = 1'b1;
        rxd   = 2'b01;
        repeat (4) @(negedge clk);
        check("reset.axiov", axiov, 1'b0);
        check("reset.axiod", axiod, 2'b00);
        check("reset.dest_ok", dest_ok, 1'b0);
        check("reset.frame_done", frame_done, 1'b0);
        check("reset.crc_ok", crc_ok, 1'b0);
        check("reset.frame_err", frame_err, 1'b0);
        run_case(100, '{31, 1'b1, 1'b0, -1, BODY, -1, 0, 0, 0, 1'b0, 1'b0});

        foreach (tbl[i]) run_case(i, tbl[i]);

        for (int i = 0; i < 20; i++) begin
            v.pre_len = $urandom_range(3, 31);
            v.bcast   = 1'($urandom_range(0, 1));
            v.rnd     = 1'b1;
            v.corrupt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, CRCD - 1)) : -1;
            sel       = $urandom_range(0, 3);
            v.n_body  = (sel == 1) ? BODY + int'($urandom_range(1, 10)) :
                        (sel == 2) ? int'($urandom_range(0, BODY - 1)) : BODY;
            v.rst_at  = -1;
            v = model(v);
            run_case(200 + i, v);
        end

        check("invariants", n_viol, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/eth_unpacker.md
# eth_unpacker

Receive-side framer for the RMII Ethernet link between FPGA1 and FPGA2. Sits on FPGA2 directly behind the PHY RMII pins. It locks onto preamble/SFD and discards the destination, source and length fields. It streams the fixed-length payload out as dibits, then checks the 32-bit FCS against a locally computed CRC. It is the exact counterpart of `eth_packer` and must accept every frame that `eth_packer` emits.

## Interface
Parameters:
- `PRE_MIN_DIBITS`, default 8: minimum count of consecutive `01` preamble dibits before an SFD `11` is accepted.
- `ADDR_DIBITS`, default 24: dibits per MAC address field.
- `LEN_DIBITS`, default 8: dibits in the length/type field.
- `DATA_DIBITS`, default 20: payload dibits per frame. Must match the transmitter.
- `CRC_DIBITS`, default 16: FCS dibits.

Ports:
- `clk`, in, 1: 50 MHz RMII reference clock. This is the single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `crsdv`, in, 1: PHY carrier-sense/data-valid.
- `rxd`, in, 2: PHY receive dibit.
- `axiov`, out, 1: payload dibit valid.
- `axiod`, out, 2: payload dibit, in wire order.
- `dest_ok`, out, 1: destination field was all ones (broadcast). Valid with `frame_done`.
- `frame_done`, out, 1: one-cycle pulse when a complete frame ends.
- `crc_ok`, out, 1: FCS matched. Valid only while `frame_done`=1, otherwise 0.
- `frame_err`, out, 1: one-cycle pulse when `crsdv` drops before the last FCS dibit.

## Operation
States:
- **WaitQuiet**: the reset state. Stay until `crsdv`=0 for one cycle, then go to Idle. This prevents locking mid-frame after a reset.
- **Idle**: when `crsdv`=1 and `rxd`=01, go to Preamble with `cnt`=1.
- **Preamble**:
  - `rxd`=01: increment `cnt`, saturating at 8191.
  - `rxd`=11 and `cnt`≥`PRE_MIN_DIBITS`: go to DestAddr with `cnt`=0.
  - `rxd`=11 with `cnt` short, or any other dibit: go to WaitQuiet with no error pulse.
- **DestAddr**: consume `ADDR_DIBITS` dibits. Clear `dest_ok` on any dibit ≠11.
- **SrcAddr**: consume `ADDR_DIBITS` dibits.
- **Length**: consume `LEN_DIBITS` dibits.
- **Data**: consume `DATA_DIBITS` dibits and forward each one on `axiod`/`axiov`.
- **Fcs**: consume `CRC_DIBITS` dibits into `rx_fcs[31:0]`.
  - FCS dibit k lands at bits {b+1,b}, where b = 24−8·(k/4) + 2·(k%4). This is the transmitter's byte-reversed, LSB-first order.
  - After the last dibit, pulse `frame_done`, drive `crc_ok` = (`rx_fcs` == computed CRC), then go to WaitQuiet.
- In any state from DestAddr through Fcs, `crsdv`=0 means: pulse `frame_err`, drop `axiov`, go to Idle.
- A 13-bit dibit counter `cnt` is shared across states and cleared on every state change.

CRC:
- `crc32` is fed `rxd` with valid asserted during DestAddr, SrcAddr, Length and Data only. Preamble/SFD and FCS are excluded.
- `crc32` reset is held from reset until the SFD is accepted, and again after `frame_done`/`frame_err`.
- The computed CRC is captured on the first Fcs cycle. This allows `crc32`'s one-cycle output latency.

## Timing
- All outputs are registered and reset to 0. `dest_ok` resets to 1 at SFD acceptance.
- Payload latency: a dibit sampled in Data at cycle t appears on `axiod` with `axiov`=1 at cycle t+1.
- Exactly `DATA_DIBITS` consecutive `axiov` cycles per good frame. There is no backpressure.
- `frame_done` is asserted the cycle after the last FCS dibit is sampled. This is 1+`ADDR_DIBITS`·2+`LEN_DIBITS`+`DATA_DIBITS`+`CRC_DIBITS` = 93 cycles after the SFD with defaults.
- `frame_done` and `frame_err` are never asserted in the same cycle.
- If `crsdv` stays high after the last FCS dibit, the block ignores it until `crsdv` falls.
- `rst` mid-frame forces WaitQuiet next cycle, with all outputs 0 and no pulse.

## Structure
- Shared package `eth_pkg` holds:
  - the state enum,
  - field-length constants, shared with `eth_packer`,
  - the `01`/`11` preamble/SFD dibit constants,
  - the broadcast pattern.
- One sub-module: the existing `crc32` (ports `clk`, `rst`, `axiiv`, `axiid`, `axiov`, `axiod`), instantiated once.
- No FIFO. The downstream consumer accepts one dibit per cycle.

## Test plan
- **Loopback**: `eth_packer` drives `eth_unpacker` (`phy_txen`→`crsdv`, `phy_txd`→`rxd`) with payload dibits 0,1,2,3 repeating. Required: 20 `axiov` cycles with the same sequence, then `frame_done`=1, `crc_ok`=1, `dest_ok`=1. Repeat 3 frames back-to-back across the 48-cycle IFG.
- **Corrupt FCS**: as loopback, but flip bit 0 of FCS dibit 5. Required: `frame_done`=1, `crc_ok`=0; payload still delivered.
- **Short preamble**: 4×`01`, then `11`, then a valid body. Required: no `axiov`, no `frame_done`; the block returns to Idle after `crsdv` falls.
- **Truncation**: drop `crsdv` after payload dibit 10. Required: 10 `axiov` cycles, one `frame_err` pulse, no `frame_done`; the next valid frame is received with `crc_ok`=1.
- **Reset mid-frame**: assert `rst` during SrcAddr while `crsdv` stays high. Required: the rest of that frame is ignored (no `axiov`), and the following frame is received correctly.
- **Non-broadcast destination**: a valid frame with destination dibit 0 = `10` and a matching FCS. Required: `frame_done`=1, `crc_ok`=1, `dest_ok`=0.
